// File: rtl/vend_pkg.sv
// vend_pkg: constants and state encoding shared by the vending FSM and the change dispenser.
package vend_pkg;
   localparam int CHG_W          = 3;
   localparam int MAX_CHANGE_DEF = 4;
   typedef enum logic [2:0] {
      IDLE, SODA_ON, SODA_GAP, COIN_WAIT, COIN_ON, COIN_GAP, DONE
   } state_t;
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter that parks at 1 and flags the last cycle of a timed state.
module pulse_timer #(
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_last
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                r_cnt <= '0;
      else if (i_load)             r_cnt <= i_val;
      else if (r_cnt > W'(1))      r_cnt <= r_cnt - W'(1);
   end
   assign o_last = r_cnt == W'(1);
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: turns a vend strobe into a soda motor pulse followed by timed nickel ejects,
// with a one-entry pending buffer and a hopper-empty stall.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int MAX_CHANGE   = MAX_CHANGE_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_soda,
   input  logic [CHG_W-1:0] i_change,
   input  logic             i_hopper_empty,
   output logic             o_soda_motor,
   output logic             o_nickel_eject,
   output logic             o_busy,
   output logic             o_stall,
   output logic             o_done,
   output logic             o_overrun,
   output logic             o_change_err
);
   localparam int TW = $clog2((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES) + 1;
   localparam logic [CHG_W-1:0] MAX_C = CHG_W'(MAX_CHANGE);

   state_t           r_state, w_next;
   logic [CHG_W-1:0] r_nick, r_pend, w_clamp, w_load_val;
   logic             r_pend_v, r_motor, r_eject, r_busy, r_done, r_overrun, r_err;
   logic             w_last, w_over, w_mid, w_drop, w_start, w_enter;
   logic [TW-1:0]    w_tval;

   assign w_over     = i_change > MAX_C;
   assign w_clamp    = w_over ? MAX_C : i_change;
   assign w_mid      = r_state != IDLE && r_state != DONE;
   assign w_drop     = i_soda && w_mid && r_pend_v;
   assign w_enter    = w_next != r_state;
   assign w_start    = w_next == SODA_ON && r_state != SODA_ON;
   assign w_load_val = (r_state == DONE && r_pend_v) ? r_pend : w_clamp;
   assign w_tval     = (w_next == SODA_ON || w_next == COIN_ON) ? TW'(PULSE_CYCLES) : TW'(GAP_CYCLES);

   pulse_timer #(.W(TW)) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_enter),
      .i_val   (w_tval),
      .o_last  (w_last)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (i_soda)          w_next = SODA_ON;
         SODA_ON:   if (w_last)          w_next = SODA_GAP;
         SODA_GAP:  if (w_last)          w_next = (r_nick == '0) ? DONE : COIN_WAIT;
         COIN_WAIT: if (!i_hopper_empty) w_next = COIN_ON;
         COIN_ON:   if (w_last)          w_next = COIN_GAP;
         COIN_GAP:  if (w_last)          w_next = (r_nick == '0) ? DONE : COIN_WAIT;
         DONE:                           w_next = (r_pend_v || i_soda) ? SODA_ON : IDLE;
         default:                        w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_nick    <= '0;
         r_pend    <= '0;
         r_pend_v  <= 1'b0;
         r_motor   <= 1'b0;
         r_eject   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_motor   <= w_next == SODA_ON;
         r_eject   <= w_next == COIN_ON;
         r_busy    <= w_next != IDLE;
         r_done    <= w_next == DONE;
         r_overrun <= w_drop;
         r_err     <= i_soda && w_over && !w_drop;
         if (w_start)
            r_nick <= w_load_val;
         else if (r_state == COIN_ON && w_last && r_nick != '0)
            r_nick <= r_nick - 1'b1;
         // DONE hands the pending entry to the new sequence and can refill it on the same edge
         if (r_state == DONE && r_pend_v) begin
            r_pend_v <= i_soda;
            r_pend   <= w_clamp;
         end else if (i_soda && w_mid && !r_pend_v) begin
            r_pend_v <= 1'b1;
            r_pend   <= w_clamp;
         end
      end
   end

   assign o_soda_motor   = r_motor;
   assign o_nickel_eject = r_eject;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_overrun      = r_overrun;
   assign o_change_err   = r_err;
   // stall follows the live sensor so it drops in the very cycle the hopper is refilled
   assign o_stall        = r_state == COIN_WAIT && i_hopper_empty;
endmodule
